// File: rtl/alu_issue_arbiter_pkg.sv
// Shared integer-ALU definitions: funct encodings, the issue request record
// and the datapath width used by the arbitrated ALU.
package alu_issue_arbiter_pkg;

   localparam int XLEN      = 32;
   // Tag field is sized for the widest tag any client uses; narrower tags zero-extend.
   localparam int MAX_TAG_W = 16;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [XLEN-1:0]      op1;
      logic [XLEN-1:0]      op2;
      logic [2:0]           funct3;
      logic [6:0]           funct7;
      logic                 imm_flag;
      logic [11:0]          imm;
      logic [MAX_TAG_W-1:0] tag;
   } alu_req_t;

endpackage

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the last accepted index;
// the pointer only moves when the caller reports an accepted handshake.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] last;
   logic             found;
   int               cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDX_W'(cand);
         end
      end
   end

   // Reset to the highest index so requester 0 is first in line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= IDX_W'(NUM_REQ - 1);
      end else if (advance) begin
         last <= idx;
      end
   end

endmodule

// File: rtl/arithmatic.sv
// Combinational RV32I-style integer ALU covering the OP and OP-IMM groups.
module arithmatic #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic            imm_flag,
   input  logic [11:0]     imm,
   output logic [XLEN-1:0] result
);
   import alu_issue_arbiter_pkg::*;

   localparam int SH_W = $clog2(XLEN);

   logic        [XLEN-1:0] opb;
   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;
   logic        [6:0]      imm_sh;
   logic        [SH_W-1:0] shamt;

   assign opb    = imm_flag ? {{(XLEN-12){imm[11]}}, imm} : op2;
   assign a_s    = op1;
   assign b_s    = opb;
   assign imm_sh = imm[6:0];
   assign shamt  = imm_flag ? imm_sh[SH_W-1:0] : op2[SH_W-1:0];

   // funct7[5] only turns ADD into SUB for register-register ops; ADDI has no subtract form.
   always_comb begin
      result = '0;
      case (funct3)
         F3_ADD:  result = (!imm_flag && funct7[5]) ? op1 - opb : op1 + opb;
         F3_SLL:  result = op1 << shamt;
         F3_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
         F3_SLTU: result = {{(XLEN-1){1'b0}}, (op1 < opb)};
         F3_XOR:  result = op1 ^ opb;
         F3_SR:   result = funct7[5] ? $unsigned(a_s >>> shamt) : op1 >> shamt;
         F3_OR:   result = op1 | opb;
         F3_AND:  result = op1 & opb;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one integer ALU among NUM_REQ requesters: round-robin issue into S1,
// ALU on S1, registered result in S2 with valid/ready backpressure.
module alu_issue_arbiter #(
   parameter int XLEN    = 32,
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4,
   parameter int STALL_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*XLEN-1:0]    req_op1,
   input  logic [NUM_REQ*XLEN-1:0]    req_op2,
   input  logic [NUM_REQ*3-1:0]       req_funct3,
   input  logic [NUM_REQ*7-1:0]       req_funct7,
   input  logic [NUM_REQ-1:0]         req_imm_flag,
   input  logic [NUM_REQ*12-1:0]      req_imm,
   input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_result,
   output logic [$clog2(NUM_REQ)-1:0] out_src,
   output logic [TAG_W-1:0]           out_tag,
   output logic [STALL_W-1:0]         stall_cnt
);
   import alu_issue_arbiter_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);

   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (&v) ? v : v + STALL_W'(1);
   endfunction

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   idx;
   logic               s1_free;
   logic               s2_free;
   logic               accept;
   alu_req_t           sel_req;
   logic [XLEN-1:0]    alu_result;

   logic               vld_p1;
   alu_req_t           req_p1;
   logic [IDX_W-1:0]   src_p1;

   logic               vld_p2;
   logic [XLEN-1:0]    result_p2;
   logic [IDX_W-1:0]   src_p2;
   logic [TAG_W-1:0]   tag_p2;
   logic [STALL_W-1:0] stall_q;

   assign s2_free   = !vld_p2 || out_ready;
   assign s1_free   = !vld_p1 || s2_free;
   assign accept    = (|req_valid) && s1_free && !flush;
   assign req_ready = grant & {NUM_REQ{s1_free && !flush}};

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant),
      .idx     (idx)
   );

   always_comb begin
      sel_req          = '0;
      sel_req.op1      = req_op1[int'(idx)*XLEN +: XLEN];
      sel_req.op2      = req_op2[int'(idx)*XLEN +: XLEN];
      sel_req.funct3   = req_funct3[int'(idx)*3 +: 3];
      sel_req.funct7   = req_funct7[int'(idx)*7 +: 7];
      sel_req.imm_flag = req_imm_flag[idx];
      sel_req.imm      = req_imm[int'(idx)*12 +: 12];
      sel_req.tag      = MAX_TAG_W'(req_tag[int'(idx)*TAG_W +: TAG_W]);
   end

   // ---- S1: issue register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
      end else if (s2_free) begin
         vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         req_p1 <= sel_req;
         src_p1 <= idx;
      end
   end

   arithmatic #(
      .XLEN     (XLEN)
   ) u_alu (
      .op1      (req_p1.op1),
      .op2      (req_p1.op2),
      .funct3   (req_p1.funct3),
      .funct7   (req_p1.funct7),
      .imm_flag (req_p1.imm_flag),
      .imm      (req_p1.imm),
      .result   (alu_result)
   );

   // ---- S2: output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2    <= 1'b0;
         result_p2 <= '0;
         src_p2    <= '0;
         tag_p2    <= '0;
         stall_q   <= '0;
      end else begin
         if (flush) begin
            vld_p2 <= 1'b0;
         end else if (s2_free) begin
            vld_p2 <= vld_p1;
         end
         if (vld_p1 && s2_free && !flush) begin
            result_p2 <= alu_result;
            src_p2    <= src_p1;
            tag_p2    <= req_p1.tag[TAG_W-1:0];
         end
         if (vld_p2 && !out_ready && !flush) begin
            stall_q <= sat_inc(stall_q);
         end
      end
   end

   assign out_valid  = vld_p2;
   assign out_result = result_p2;
   assign out_src    = src_p2;
   assign out_tag    = tag_p2;
   assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: ALU vector table plus hand-written
// latency, fairness, backpressure, flush, reset and saturation sequences.
module tb_alu_issue_arbiter;

   typedef struct {
      int          r;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        immf;
      logic [11:0] imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [1:0]  req_valid;
   logic [63:0] req_op1;
   logic [63:0] req_op2;
   logic [5:0]  req_funct3;
   logic [13:0] req_funct7;
   logic [1:0]  req_imm_flag;
   logic [23:0] req_imm;
   logic [7:0]  req_tag;
   logic        out_ready;

   logic [1:0]  req_ready;
   logic        out_valid;
   logic [31:0] out_result;
   logic [0:0]  out_src;
   logic [3:0]  out_tag;
   logic [15:0] stall_cnt;

   logic [1:0]  req_ready_b;
   logic        out_valid_b;
   logic [31:0] out_result_b;
   logic [0:0]  out_src_b;
   logic [3:0]  out_tag_b;
   logic [3:0]  stall_cnt_b;

   int n_chk  = 0;
   int n_fail = 0;

   vec_t vecs[15];

   always #5 clk = ~clk;

   alu_issue_arbiter #(.XLEN(32), .NUM_REQ(2), .TAG_W(4), .STALL_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2), .req_funct3(req_funct3), .req_funct7(req_funct7),
      .req_imm_flag(req_imm_flag), .req_imm(req_imm), .req_tag(req_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_src(out_src), .out_tag(out_tag), .stall_cnt(stall_cnt)
   );

   alu_issue_arbiter #(.XLEN(32), .NUM_REQ(2), .TAG_W(4), .STALL_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready_b),
      .req_op1(req_op1), .req_op2(req_op2), .req_funct3(req_funct3), .req_funct7(req_funct7),
      .req_imm_flag(req_imm_flag), .req_imm(req_imm), .req_tag(req_tag),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_result(out_result_b),
      .out_src(out_src_b), .out_tag(out_tag_b), .stall_cnt(stall_cnt_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int r, input logic [2:0] f3, input logic [6:0] f7,
                               input logic immf, input logic [11:0] imm, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp);
      vec_t v;
      v.r = r; v.f3 = f3; v.f7 = f7; v.immf = immf; v.imm = imm;
      v.a = a; v.b = b; v.tag = tag; v.exp = exp;
      return v;
   endfunction

   task automatic set_req(input vec_t v);
      req_valid[v.r]          = 1'b1;
      req_op1[v.r*32 +: 32]   = v.a;
      req_op2[v.r*32 +: 32]   = v.b;
      req_funct3[v.r*3 +: 3]  = v.f3;
      req_funct7[v.r*7 +: 7]  = v.f7;
      req_imm_flag[v.r]       = v.immf;
      req_imm[v.r*12 +: 12]   = v.imm;
      req_tag[v.r*4 +: 4]     = v.tag;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v0, v1, v2;
      int   t;
      int   ready_cycles;
      int   sent;
      int   got;
      logic acc;

      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; req_valid = '0;
      req_op1 = '0; req_op2 = '0; req_funct3 = '0; req_funct7 = '0;
      req_imm_flag = '0; req_imm = '0; req_tag = '0;

      vecs[0]  = mk(0, 3'b000, 7'h00, 1'b0, 12'h000, 32'd5,         32'd7,         4'd3,  32'd12);
      vecs[1]  = mk(1, 3'b000, 7'h20, 1'b0, 12'h000, 32'd10,        32'd4,         4'd1,  32'd6);
      vecs[2]  = mk(1, 3'b101, 7'h20, 1'b1, 12'h404, 32'h8000_0000, 32'd0,         4'd2,  32'hF800_0000);
      vecs[3]  = mk(1, 3'b011, 7'h00, 1'b1, 12'hFFF, 32'd1,         32'd0,         4'd4,  32'd1);
      vecs[4]  = mk(0, 3'b010, 7'h00, 1'b0, 12'h000, 32'hFFFF_FFFF, 32'd1,         4'd5,  32'd1);
      vecs[5]  = mk(0, 3'b011, 7'h00, 1'b0, 12'h000, 32'hFFFF_FFFF, 32'd1,         4'd6,  32'd0);
      vecs[6]  = mk(0, 3'b001, 7'h00, 1'b0, 12'h000, 32'd1,         32'd31,        4'd7,  32'h8000_0000);
      vecs[7]  = mk(0, 3'b101, 7'h00, 1'b0, 12'h000, 32'h8000_0000, 32'd4,         4'd8,  32'h0800_0000);
      vecs[8]  = mk(1, 3'b100, 7'h00, 1'b0, 12'h000, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd9,  32'h0FF0_0FF0);
      vecs[9]  = mk(0, 3'b110, 7'h00, 1'b0, 12'h000, 32'h1234_0000, 32'h0000_5678, 4'd10, 32'h1234_5678);
      vecs[10] = mk(0, 3'b111, 7'h00, 1'b0, 12'h000, 32'hFFFF_0000, 32'h1234_5678, 4'd11, 32'h1234_0000);
      vecs[11] = mk(1, 3'b000, 7'h00, 1'b1, 12'hFFF, 32'd10,        32'd0,         4'd12, 32'd9);
      vecs[12] = mk(0, 3'b000, 7'h20, 1'b0, 12'h000, 32'd0,         32'd1,         4'd13, 32'hFFFF_FFFF);
      vecs[13] = mk(1, 3'b111, 7'h00, 1'b1, 12'h800, 32'hFFFF_FFFF, 32'd0,         4'd14, 32'hFFFF_F800);
      vecs[14] = mk(1, 3'b001, 7'h00, 1'b1, 12'h01F, 32'd3,         32'd0,         4'd15, 32'h8000_0000);

      // ---- reset state ----
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_stall", stall_cnt, 0);
      do_reset();
      #1;
      v0 = mk(0, 3'b000, 7'h00, 1'b0, 12'h000, 32'd1, 32'd1, 4'd1, 32'd2);
      v1 = mk(1, 3'b000, 7'h20, 1'b0, 12'h000, 32'd10, 32'd4, 4'd2, 32'd6);
      set_req(v0); set_req(v1);
      #1;
      check("rst_first_priority", req_ready, 2'b01);
      req_valid = '0;
      @(negedge clk); #1;
      check("withdraw_no_effect", out_valid, 0);

      // ---- single op: latency and one-cycle ready ----
      @(negedge clk);
      set_req(vecs[0]);
      #1;
      ready_cycles = 0;
      for (int k = 0; k < 4; k++) begin
         if (req_ready[0]) ready_cycles++;
         if (k == 1) check("single_lat1_valid", out_valid, 0);
         if (k == 2) begin
            check("single_lat2_valid", out_valid, 1);
            check("single_result", out_result, 12);
            check("single_src", out_src, 0);
            check("single_tag", out_tag, 3);
         end
         if (k == 3) check("single_drained", out_valid, 0);
         @(posedge clk); #1;
         if (req_ready[0] === 1'b0 || k == 0) req_valid[0] = 1'b0;
         @(negedge clk); #1;
      end
      check("single_ready_cycles", ready_cycles, 1);

      // ---- ALU vector table ----
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         set_req(vecs[i]);
         #1;
         t = 0;
         while (!req_ready[vecs[i].r] && t < 10) begin
            @(negedge clk); #1; t++;
         end
         check($sformatf("vec%0d_ready", i), req_ready[vecs[i].r], 1);
         @(posedge clk); #1;
         req_valid = '0;
         @(negedge clk); #1;
         t = 0;
         while (!out_valid && t < 10) begin
            @(negedge clk); #1; t++;
         end
         check($sformatf("vec%0d_latency", i), t, 1);
         check($sformatf("vec%0d_result", i), out_result, vecs[i].exp);
         check($sformatf("vec%0d_src", i), out_src, vecs[i].r);
         check($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
      end

      // ---- round-robin fairness ----
      do_reset();
      @(negedge clk);
      set_req(v0); set_req(v1);
      for (int k = 0; k < 8; k++) begin
         #1;
         if (k == 6) req_valid = '0;
         if (k < 6) check($sformatf("rr_grant%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
         if (k >= 2) begin
            check($sformatf("rr_valid%0d", k), out_valid, 1);
            check($sformatf("rr_src%0d", k), out_src, k % 2);
            check($sformatf("rr_result%0d", k), out_result, (k % 2) ? 32'd6 : 32'd2);
         end
         @(negedge clk);
      end

      // ---- backpressure: 4 ops, 5 stalled cycles ----
      do_reset();
      out_ready = 1'b0;
      sent = 0; got = 0;
      @(negedge clk);
      set_req(mk(0, 3'b000, 7'h00, 1'b0, 12'h000, 32'd100, 32'd0, 4'd0, 32'd100));
      for (int c = 0; c < 30 && got < 4; c++) begin
         #1;
         if (c >= 2 && c <= 6) begin
            check($sformatf("bp_hold%0d", c), out_result, 100);
            check($sformatf("bp_ready%0d", c), req_ready, 2'b00);
         end
         if (c == 7) check("bp_stall", stall_cnt, 5);
         acc = req_valid[0] & req_ready[0];
         if (out_valid && out_ready) begin
            check($sformatf("bp_order%0d", got), out_result, 100 + got);
            check($sformatf("bp_tag%0d", got), out_tag, got);
            got++;
         end
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            if (sent < 4)
               set_req(mk(0, 3'b000, 7'h00, 1'b0, 12'h000, 32'd100 + sent, 32'd0, 4'(sent), 32'd0));
            else
               req_valid = '0;
         end
         out_ready = (c + 1 >= 7);
         @(negedge clk);
      end
      check("bp_count", got, 4);
      #1;
      check("bp_no_dup", out_valid, 0);
      check("bp_stall_final", stall_cnt, 5);

      // ---- flush with S1 and S2 full ----
      do_reset();
      out_ready = 1'b0;
      @(negedge clk);
      set_req(mk(0, 3'b000, 7'h00, 1'b0, 12'h000, 32'd1, 32'd2, 4'd5, 32'd3));
      @(posedge clk); #1;
      req_valid = '0;
      set_req(mk(1, 3'b000, 7'h00, 1'b0, 12'h000, 32'd3, 32'd4, 4'd6, 32'd7));
      @(negedge clk); #1;
      check("flush_fill_ready", req_ready, 2'b10);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk); #1;
      check("flush_pre_valid", out_valid, 1);
      flush = 1'b1;
      v2 = mk(0, 3'b000, 7'h00, 1'b0, 12'h000, 32'd20, 32'd22, 4'd7, 32'd42);
      set_req(v2); set_req(v1);
      #1;
      check("flush_ready", req_ready, 2'b00);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk); #1;
      check("flush_out_valid", out_valid, 0);
      check("flush_stall", stall_cnt, 0);
      check("flush_ptr", req_ready, 2'b01);
      out_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk); #1;
      check("flush_s1_cleared", out_valid, 0);
      @(negedge clk); #1;
      check("flush_next_valid", out_valid, 1);
      check("flush_next_result", out_result, 42);
      check("flush_next_src", out_src, 0);
      check("flush_next_tag", out_tag, 7);

      // ---- asynchronous reset mid-stream ----
      do_reset();
      @(negedge clk);
      set_req(v0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("ar_pre_valid", out_valid, 1);
      check("ar_pre_result", out_result, 2);
      check("ar_pre_stall", stall_cnt, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", out_valid, 0);
      check("ar_result", out_result, 0);
      check("ar_tag", out_tag, 0);
      check("ar_src", out_src, 0);
      check("ar_stall", stall_cnt, 0);
      req_valid = '0;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      set_req(v0); set_req(v1);
      #1;
      check("ar_first_priority", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = '0;

      // ---- stall counter saturation (STALL_W=4 instance) ----
      do_reset();
      out_ready = 1'b0;
      @(negedge clk);
      set_req(v0);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk);
      repeat (15) @(posedge clk);
      @(negedge clk); #1;
      check("sat_at_15", stall_cnt_b, 15);
      check("wide_at_15", stall_cnt, 15);
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      check("sat_hold", stall_cnt_b, 15);
      check("wide_at_20", stall_cnt, 20);
      out_ready = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
